alu_op_sequencer: RTL and testbench

- Sequential issue/retire stage that sits directly upstream of the 8-bit logic ALU (AND/OR/NAND/NOR, 2-bit opcode).
- Accepts operations over a valid/ready handshake and registers the operands and opcode that drive the ALU.
- Captures the ALU's combinational result and presents it downstream over a second valid/ready handshake.
- Supports result chaining (previous result used as operand A) and keeps a count of retired operations.
- The ALU is instantiated by the parent; this block connects to it through its alu_* ports.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_op_sequencer.sv | 102 ++++++++++
 tb/tb_alu_op_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit logic ALU and its op sequencer.
// Opcode encoding, data width and sequencer state encoding.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [1:0]        opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issue/retire stage in front of the logic ALU: accept -> one settle cycle -> hold result.
// out_valid two cycles after accept; result held stable under out_ready=0, one op per 3 cycles.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [1:0]         in_opcode,
    input  logic               in_chain,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [1:0]         alu_opcode,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [1:0]         out_opcode,
    output logic [COUNT_W-1:0] op_count
);

    seq_state_t         r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    data_t              r_alu_a;
    data_t              r_alu_b;
    opcode_t            r_alu_opcode;
    data_t              r_out_result;
    opcode_t            r_out_opcode;
    logic [COUNT_W-1:0] r_op_count;
    data_t              r_last_result;
    logic               r_last_valid;

    // Chaining only takes effect once a result has actually retired since reset.
    data_t w_operand_a;
    assign w_operand_a = (in_chain && r_last_valid) ? r_last_result : in_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_opcode  <= '0;
            r_out_result  <= '0;
            r_out_opcode  <= '0;
            r_op_count    <= '0;
            r_last_result <= '0;
            r_last_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_alu_a      <= w_operand_a;
                        r_alu_b      <= in_b;
                        r_alu_opcode <= in_opcode;
                        r_in_ready   <= 1'b0;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU inputs have been stable for this whole cycle.
                    r_out_result <= alu_result;
                    r_out_opcode <= r_alu_opcode;
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_last_result <= r_out_result;
                        r_last_valid  <= 1'b1;
                        r_op_count    <= r_op_count + COUNT_W'(1);
                        r_out_valid   <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign out_result = r_out_result;
    assign out_opcode = r_out_opcode;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU as the parent would wire it.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic [1:0]    in_opcode;
    logic          in_chain;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [1:0]    alu_opcode;
    logic [7:0]    alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_result;
    logic [1:0]    out_opcode;
    logic [CW-1:0] op_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]    sb_res[$];
    logic [1:0]    sb_op[$];
    logic [CW-1:0] exp_count;

    alu_op_sequencer #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_chain   (in_chain),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .op_count   (op_count)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NAND: return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_a, alu_b, alu_opcode);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation; hold = cycles of out_ready=0 while in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic chain, input logic [7:0] exp_a,
                          input logic [7:0] exp_res, input int hold);
        logic [7:0] res;
        logic [1:0] rop;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1);
        check_eq("idle_out_valid", out_valid, 0);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        in_chain  = chain;
        out_ready = (hold == 0);
        sb_res.push_back(exp_res);
        sb_op.push_back(op);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        check_eq("exec_alu_a", alu_a, exp_a);
        check_eq("exec_alu_b", alu_b, b);
        check_eq("exec_alu_op", alu_opcode, op);
        check_eq("exec_in_ready", in_ready, 0);
        check_eq("exec_out_valid", out_valid, 0);
        @(negedge clk);
        check_eq("done_out_valid", out_valid, 1);
        check_eq("done_in_ready", in_ready, 0);
        res = sb_res.pop_front();
        rop = sb_op.pop_front();
        check_eq("out_result", out_result, res);
        check_eq("out_opcode", out_opcode, rop);
        for (int i = 0; i < hold; i++) begin
            // in_valid with junk must be ignored outside IDLE
            in_valid = 1'b1;
            @(negedge clk);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_out_result", out_result, res);
            check_eq("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_count = exp_count + 1'b1;
        check_eq("retire_in_ready", in_ready, 1);
        check_eq("retire_out_valid", out_valid, 0);
        check_eq("op_count", op_count, exp_count);
        check_eq("hold_alu_a", alu_a, exp_a);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] rop;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_opcode = '0;
        in_chain  = 1'b0;
        out_ready = 1'b0;
        exp_count = '0;
        #12;
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_op_count", op_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // chain right after reset falls back to in_a
        run_op(8'h55, 8'hFF, OP_OR, 1'b1, 8'h55, 8'hFF, 0);

        run_op(8'hF0, 8'h3C, OP_AND,  1'b0, 8'hF0, 8'h30, 0);
        run_op(8'hF0, 8'h3C, OP_OR,   1'b0, 8'hF0, 8'hFC, 0);
        run_op(8'hF0, 8'h3C, OP_NAND, 1'b0, 8'hF0, 8'hCF, 0);
        run_op(8'hF0, 8'h3C, OP_NOR,  1'b0, 8'hF0, 8'h03, 0);

        run_op(8'hF0, 8'h3C, OP_AND, 1'b0, 8'hF0, 8'h30, 0);
        run_op(8'hAA, 8'h0F, OP_NOR, 1'b1, 8'h30, 8'hC0, 0);

        run_op(8'h5A, 8'h0F, OP_NAND, 1'b0, 8'h5A, 8'hF5, 5);

        // reset in the middle of EXEC
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = 8'h12;
        in_b      = 8'h34;
        in_opcode = OP_OR;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_alu_a", alu_a, 8'h12);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_alu_a", alu_a, 0);
        check_eq("mid_rst_alu_b", alu_b, 0);
        check_eq("mid_rst_out_result", out_result, 0);
        check_eq("mid_rst_op_count", op_count, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_out_valid", out_valid, 0);
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_pulse", out_valid, 0);
        end
        out_ready = 1'b0;
        run_op(8'h0F, 8'hF0, OP_OR, 1'b1, 8'h0F, 8'hFF, 0);

        // sixteen more retirements wrap the 4-bit counter 15 -> 0 -> 1
        for (int k = 0; k < 16; k++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom_range(0, 3));
            run_op(ra, rb, rop, 1'b0, ra, alu_ref(ra, rb, rop), k % 3);
        end
        check_eq("wrap_final", op_count, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
